// File: rtl/ped_crossing_if.sv
// Board-pin bundle for the pedestrian crossing sequencer: raw button in, lamp drives out.
interface ped_crossing_if;
    logic pin1_ped_button;
    logic pin4_green;
    logic pin5_yellow;
    logic pin6_red;
    logic pin7_ped_green;
    logic pin8_ped_red;
    logic pin9_ped_wait;

    modport master (
        output pin1_ped_button,
        input  pin4_green, pin5_yellow, pin6_red,
        input  pin7_ped_green, pin8_ped_red, pin9_ped_wait
    );

    modport slave (
        input  pin1_ped_button,
        output pin4_green, pin5_yellow, pin6_red,
        output pin7_ped_green, pin8_ped_red, pin9_ped_wait
    );
endinterface

// File: rtl/ped_crossing_scheduler.sv
// Demand-driven pedestrian crossing sequencer: debounced button request, minimum car green,
// then YELLOW -> ALLRED -> PEDGREEN -> PEDCLEAR -> GREEN. Lamps are a pure decode of state.
//
// state    | meaning
// INIT     | after reset, all red for ALLRED_S
// GREEN    | car green, waits for min green and a request
// YELLOW   | car yellow
// ALLRED   | all red before pedestrians go
// PEDGREEN | pedestrian green, request cleared on entry
// PEDCLEAR | pedestrian red clearance before car green
module ped_crossing_scheduler #(
    parameter int unsigned TIMER_SCALE    = 16000000,
    parameter int unsigned MIN_GREEN_S    = 10,
    parameter int unsigned YELLOW_S       = 5,
    parameter int unsigned ALLRED_S       = 2,
    parameter int unsigned PED_GREEN_S    = 10,
    parameter int unsigned PED_CLEAR_S    = 5,
    parameter int unsigned DEBOUNCE_TICKS = 160000
) (
    input logic           pin3_clk_16mhz,
    input logic           pin2_rst_n,
    ped_crossing_if.slave pins
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_GREEN    = 3'd1,
        S_YELLOW   = 3'd2,
        S_ALLRED   = 3'd3,
        S_PEDGREEN = 3'd4,
        S_PEDCLEAR = 3'd5
    } state_t;

    localparam logic [29:0] T_MIN_GREEN = 30'(MIN_GREEN_S * TIMER_SCALE - 1);
    localparam logic [29:0] T_YELLOW    = 30'(YELLOW_S * TIMER_SCALE - 1);
    localparam logic [29:0] T_ALLRED    = 30'(ALLRED_S * TIMER_SCALE - 1);
    localparam logic [29:0] T_PED_GREEN = 30'(PED_GREEN_S * TIMER_SCALE - 1);
    localparam logic [29:0] T_PED_CLEAR = 30'(PED_CLEAR_S * TIMER_SCALE - 1);

    localparam int unsigned    DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_TOP = DB_W'(DEBOUNCE_TICKS - 1);

    state_t          state_q, state_d;
    logic [29:0]     timer_q, timer_d;
    logic [1:0]      sync_q, sync_d;
    logic            db_q, db_d;
    logic            db_dly_q, db_dly_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            req_q, req_d;
    logic            timer_done;

    logic lamp_green, lamp_yellow, lamp_red, lamp_ped_green, lamp_ped_red;

    always_ff @(posedge pin3_clk_16mhz or negedge pin2_rst_n) begin
        if (!pin2_rst_n) begin
            state_q  <= S_INIT;
            timer_q  <= T_ALLRED;
            sync_q   <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            db_cnt_q <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sync_q   <= sync_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            db_cnt_q <= db_cnt_d;
            req_q    <= req_d;
        end
    end

    // Debouncer: level flips only after DEBOUNCE_TICKS consecutive disagreeing samples.
    always_comb begin
        sync_d   = {sync_q[0], pins.pin1_ped_button};
        db_d     = db_q;
        db_cnt_d = '0;
        db_dly_d = db_q;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == DB_TOP) begin
                db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign timer_done = (timer_q == 30'd0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_done ? 30'd0 : timer_q - 30'd1;
        case (state_q)
            S_INIT: if (timer_done) begin
                state_d = S_GREEN;
                timer_d = T_MIN_GREEN;
            end
            S_GREEN: if (timer_done && req_q) begin
                state_d = S_YELLOW;
                timer_d = T_YELLOW;
            end
            S_YELLOW: if (timer_done) begin
                state_d = S_ALLRED;
                timer_d = T_ALLRED;
            end
            S_ALLRED: if (timer_done) begin
                state_d = S_PEDGREEN;
                timer_d = T_PED_GREEN;
            end
            S_PEDGREEN: if (timer_done) begin
                state_d = S_PEDCLEAR;
                timer_d = T_PED_CLEAR;
            end
            S_PEDCLEAR: if (timer_done) begin
                state_d = S_GREEN;
                timer_d = T_MIN_GREEN;
            end
            default: begin
                state_d = S_INIT;
                timer_d = T_ALLRED;
            end
        endcase
    end

    // The clear on PEDGREEN entry overrides a press landing on the same cycle.
    always_comb begin
        req_d = req_q;
        if (db_q && !db_dly_q && state_q != S_PEDGREEN) req_d = 1'b1;
        if (state_q == S_ALLRED && timer_done) req_d = 1'b0;
    end

    always_comb begin
        lamp_green     = 1'b0;
        lamp_yellow    = 1'b0;
        lamp_red       = 1'b1;
        lamp_ped_green = 1'b0;
        lamp_ped_red   = 1'b1;
        case (state_q)
            S_GREEN: begin
                lamp_green = 1'b1;
                lamp_red   = 1'b0;
            end
            S_YELLOW: begin
                lamp_yellow = 1'b1;
                lamp_red    = 1'b0;
            end
            S_PEDGREEN: begin
                lamp_ped_green = 1'b1;
                lamp_ped_red   = 1'b0;
            end
            default: ;
        endcase
    end

    assign pins.pin4_green     = lamp_green;
    assign pins.pin5_yellow    = lamp_yellow;
    assign pins.pin6_red       = lamp_red;
    assign pins.pin7_ped_green = lamp_ped_green;
    assign pins.pin8_ped_red   = lamp_ped_red;
    assign pins.pin9_ped_wait  = req_q;

endmodule
